count_run_ctrl: RTL and testbench
=================================

Name: count_run_ctrl

Overview:
Run/pause/clear sequencer for the 8-bit synchronous T-flip-flop counter that drives the HEX0/HEX1 hex display.
- Converts three push-button command levels into rising-edge commands.
- Runs a prescaler that paces counting.
- Emits one-cycle count-enable (the counter's T input) and one-cycle clear pulses.
- Keeps a mirror of the count value to detect the terminal count.
- Sits between the board keys/switches and the counter datapath.

Parameters:
CNT_W, 8, width of counter and mirror.
PRESCALE, 50000000, clk cycles per count step (1 Hz at 50 MHz); must be >= 2.
LIMIT, 255, terminal count value; 1 <= LIMIT <= 2^CNT_W-1.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
start_btn  in  1  start/resume command level, active-high, already synchronised.
stop_btn  in  1  pause command level, active-high, already synchronised.
clr_btn  in  1  clear command level, active-high, already synchronised.
cnt_en  out  1  one-cycle pulse; drives counter T input.
cnt_clr  out  1  one-cycle pulse; synchronous clear of the counter.
count  out  CNT_W  mirror of the counter value.
state  out  2  FSM state code.
running  out  1  high when state==RUN.
done  out  1  high when state==DONE.

Behaviour:
- Clocking/reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: state=IDLE, prescaler=0, count=0, cnt_en=0, cnt_clr=0, edge-detect history regs=1.
  - A button held through reset produces no command.
- Commands:
  - cmd_x = x_btn & ~prev_x, where prev_x is registered each cycle.
  - Commands act at the same edge they are detected.
  - Priority on simultaneous commands: clr > stop > start.
- States (2 bits): IDLE=00, RUN=01, PAUSE=10, DONE=11.
- IDLE:
  - prescaler held at 0.
  - start -> RUN.
  - stop ignored.
- RUN:
  - If prescaler==PRESCALE-1: prescaler<=0 (a "tick"). Otherwise prescaler<=prescaler+1.
  - On a tick with count < LIMIT-1: cnt_en<=1.
  - On a tick with count==LIMIT-1: cnt_en<=1 and state<=DONE.
  - stop -> PAUSE; a tick in the same cycle is discarded (no cnt_en).
- PAUSE:
  - prescaler holds its value.
  - start -> RUN, resuming from the held prescaler value.
- DONE:
  - count holds at LIMIT; done=1.
  - start -> cnt_clr<=1, prescaler<=0, RUN.
  - stop ignored.
- clr in any state: cnt_clr<=1, prescaler<=0, state<=IDLE.
- Pulse registers: cnt_en and cnt_clr are registered and default to 0 each cycle; never both high.
- Mirror update, at each edge:
  - if cnt_clr==1: count<=0.
  - else if cnt_en==1: count<=count+1, modulo 2^CNT_W.
  - The mirror therefore matches the external counter cycle-for-cycle.
- First cnt_en after entering RUN from IDLE or DONE: high in the cycle exactly PRESCALE cycles after state first reads RUN.
- running and done decode directly from state.

Optional Feature:
Macro AUTO_WRAP_EN.
- Defined:
  - DONE is unreachable.
  - Tick with count < LIMIT -> cnt_en.
  - Tick with count==LIMIT -> cnt_clr instead of cnt_en; state stays RUN.
  - The counter cycles 0..LIMIT continuously.
- Undefined: stop-at-terminal behaviour as above.

Decomposition:
- Package count_run_ctrl_pkg holds:
  - state code localparams ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE;
  - the 2-bit state width constant.
- Sub-module rise_det: 1-bit rising-edge detector with a reset-to-1 history register and the same clk/rst. Instantiated three times.

Test Plan:
All scenarios use PRESCALE=4, LIMIT=5.
1. Reset held 3 cycles with start_btn=1, then released with start_btn still high -> state=00, count=0, no cnt_en, no transition.
2. start pulse -> running=1; cnt_en high on every 4th cycle; count steps 0,1,2,3,4,5. On the enable that takes count to 5, state=11 and done=1; no further cnt_en.
3. RUN with prescaler=2, stop pulse -> PAUSE; prescaler stays 2 for 10 cycles. start -> the next cnt_en arrives 2 cycles after RUN re-entry.
4. start, stop and clr asserted in the same cycle during RUN at count=3 -> cnt_clr one cycle, count=0 next cycle, state=IDLE, cnt_en never asserted.
5. In DONE (count=5), start pulse -> cnt_clr one cycle, count=0, RUN; first cnt_en 4 cycles later.
6. With AUTO_WRAP_EN defined, run 30 cycles -> count sequence 0..5,0,1,...; cnt_clr pulses at the wrap; done stays 0.

Source files
------------

// File: rtl/count_run_ctrl_pkg.sv
// Shared types and constants for the count_run_ctrl sequencer.
package count_run_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/count_run_ctrl_rise_det.sv
// rise_det: 1-bit rising-edge detector.
// The history register resets to 1 so a level held through reset is not a command.
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    // Remember last cycle's level.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/count_run_ctrl.sv
// count_run_ctrl: run/pause/clear sequencer for the hex-display counter.
// Turns button levels into edge commands, paces counting with a prescaler,
// emits one-cycle cnt_en / cnt_clr pulses and mirrors the counter value.
// Optional macro AUTO_WRAP_EN: wrap 0..LIMIT continuously instead of stopping in DONE.
module count_run_ctrl
    import count_run_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned PRESCALE = 50000000,
    parameter int unsigned LIMIT    = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_btn,
    input  logic               stop_btn,
    input  logic               clr_btn,
    output logic               cnt_en,
    output logic               cnt_clr,
    output logic [CNT_W-1:0]   count,
    output logic [STATE_W-1:0] state,
    output logic               running,
    output logic               done
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
`ifdef AUTO_WRAP_EN
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LIMIT);
`else
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(LIMIT - 1);
`endif

    logic cmd_start;
    logic cmd_stop;
    logic cmd_clr;

    state_e           state_q, state_d;
    logic [PS_W-1:0]  presc_q, presc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             en_q, en_d;
    logic             clr_q, clr_d;
    logic             tick;

    rise_det u_start_det (.clk(clk), .rst(rst), .d_i(start_btn), .rise_o(cmd_start));
    rise_det u_stop_det  (.clk(clk), .rst(rst), .d_i(stop_btn),  .rise_o(cmd_stop));
    rise_det u_clr_det   (.clk(clk), .rst(rst), .d_i(clr_btn),   .rise_o(cmd_clr));

    // State, prescaler, pulse and mirror registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            count_q <= '0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            count_q <= count_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
        end
    end

    // Next-state, prescaler and pulse decisions; clr beats stop beats start.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        en_d    = 1'b0;
        clr_d   = 1'b0;
        tick    = (presc_q == PS_LAST);
        if (cmd_clr) begin
            clr_d   = 1'b1;
            presc_d = '0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    presc_d = '0;
                    if (cmd_start) state_d = ST_RUN;
                end
                ST_RUN: begin
                    // A stop freezes the prescaler and drops any tick of this cycle.
                    if (cmd_stop) begin
                        state_d = ST_PAUSE;
                    end else begin
                        presc_d = tick ? '0 : presc_q + PS_W'(1);
                        if (tick) begin
`ifdef AUTO_WRAP_EN
                            if (count_q == CNT_LIMIT) clr_d = 1'b1;
                            else                      en_d  = 1'b1;
`else
                            en_d = 1'b1;
                            if (count_q == CNT_PRE) state_d = ST_DONE;
`endif
                        end
                    end
                end
                ST_PAUSE: begin
                    if (cmd_start) state_d = ST_RUN;
                end
                ST_DONE: begin
                    if (cmd_start) begin
                        clr_d   = 1'b1;
                        presc_d = '0;
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Mirror follows the registered pulses exactly as the external counter does.
    always_comb begin
        count_d = count_q;
        if (clr_q)     count_d = '0;
        else if (en_q) count_d = count_q + CNT_W'(1);
    end

    assign cnt_en  = en_q;
    assign cnt_clr = clr_q;
    assign count   = count_q;
    assign state   = state_q;
    assign running = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_count_run_ctrl.sv
// Self-checking bench for count_run_ctrl (PRESCALE=4, LIMIT=5).
module tb_count_run_ctrl;

    localparam int W = 8;
    localparam int P = 4;
    localparam int L = 5;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_btn;
    logic         stop_btn;
    logic         clr_btn;
    logic         cnt_en;
    logic         cnt_clr;
    logic [W-1:0] count;
    logic [1:0]   state;
    logic         running;
    logic         done;

    count_run_ctrl #(.CNT_W(W), .PRESCALE(P), .LIMIT(L)) dut (
        .clk(clk), .rst(rst),
        .start_btn(start_btn), .stop_btn(stop_btn), .clr_btn(clr_btn),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr), .count(count),
        .state(state), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: elapsed RUN cycles since restart; a step happens when
    // the elapsed count completes a multiple of P.
    int m_st;
    int m_cnt;
    int m_elapsed;
    bit m_en;
    bit m_clr;
    bit pv_s, pv_p, pv_c;

    typedef struct {
        bit s;
        bit p;
        bit c;
        int n;
        int st;
        int cnt;
        bit en;
        bit clr;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit cs, cp, cc, tk, n_en, n_clr;
        int old_cnt;
        if (rst) begin
            m_st = S_IDLE; m_cnt = 0; m_elapsed = 0; m_en = 0; m_clr = 0;
            pv_s = 1; pv_p = 1; pv_c = 1;
            return;
        end
        cs = start_btn && !pv_s;
        cp = stop_btn && !pv_p;
        cc = clr_btn && !pv_c;
        pv_s = start_btn; pv_p = stop_btn; pv_c = clr_btn;
        old_cnt = m_cnt;
        n_en = 0; n_clr = 0;
        tk = (m_elapsed % P) == (P - 1);
        if (cc) begin
            n_clr = 1; m_elapsed = 0; m_st = S_IDLE;
        end else if (m_st == S_IDLE) begin
            if (cs) m_st = S_RUN;
        end else if (m_st == S_RUN) begin
            if (cp) m_st = S_PAUSE;
            else begin
                m_elapsed++;
                if (tk) begin
`ifdef AUTO_WRAP_EN
                    if (old_cnt < L) n_en = 1;
                    else if (old_cnt == L) n_clr = 1;
`else
                    n_en = 1;
                    if (old_cnt == L - 1) m_st = S_DONE;
`endif
                end
            end
        end else if (m_st == S_PAUSE) begin
            if (cs) m_st = S_RUN;
        end else begin
            if (cs) begin n_clr = 1; m_elapsed = 0; m_st = S_RUN; end
        end
        if (m_clr) m_cnt = 0;
        else if (m_en) m_cnt = (old_cnt + 1) % (1 << W);
        m_en = n_en;
        m_clr = n_clr;
    endtask

    // One clock: advance the model at the edge, compare mid-cycle.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model_state", int'(state), m_st);
        chk("model_count", int'(count), m_cnt);
        chk("model_flags", int'({running, done, cnt_en, cnt_clr}),
            int'({m_st == S_RUN, m_st == S_DONE, m_en, m_clr}));
    endtask

    task automatic add(input bit s, input bit p, input bit c, input int n,
                       input int st, input int cnt, input bit en, input bit clr);
        vt.push_back('{s, p, c, n, st, cnt, en, clr});
    endtask

    initial begin
        int seq[$];
        int exp_seq[$];
        bit saw_clr;
        bit saw_done;

        rst = 1'b1; start_btn = 1'b1; stop_btn = 1'b0; clr_btn = 1'b0;

        // Reset with start held, then release reset with start still high.
        repeat (3) tick();
        chk("reset_state", int'(state), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_pulses", int'({cnt_en, cnt_clr}), 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("held_start_state", int'(state), 0);
        chk("held_start_en", int'(cnt_en), 0);
        start_btn = 1'b0;
        tick();

`ifndef AUTO_WRAP_EN
        // Run to DONE, restart from DONE, pause/resume, simultaneous commands.
        add(1,0,0,1,  S_RUN,  0,0,0);
        add(0,0,0,3,  S_RUN,  0,0,0);
        add(0,0,0,1,  S_RUN,  0,1,0);
        add(0,0,0,1,  S_RUN,  1,0,0);
        add(0,0,0,3,  S_RUN,  1,1,0);
        add(0,0,0,4,  S_RUN,  2,1,0);
        add(0,0,0,4,  S_RUN,  3,1,0);
        add(0,0,0,4,  S_DONE, 4,1,0);
        add(0,0,0,1,  S_DONE, 5,0,0);
        add(0,0,0,8,  S_DONE, 5,0,0);
        add(0,1,0,2,  S_DONE, 5,0,0);
        add(1,0,0,1,  S_RUN,  5,0,1);
        add(0,0,0,1,  S_RUN,  0,0,0);
        add(0,0,0,3,  S_RUN,  0,1,0);
        add(0,0,0,2,  S_RUN,  1,0,0);
        add(0,1,0,1,  S_PAUSE,1,0,0);
        add(0,0,0,10, S_PAUSE,1,0,0);
        add(1,0,0,1,  S_RUN,  1,0,0);
        add(0,0,0,1,  S_RUN,  1,0,0);
        add(0,0,0,1,  S_RUN,  1,1,0);
        add(0,0,0,1,  S_RUN,  2,0,0);
        add(0,0,0,4,  S_RUN,  3,0,0);
        add(1,1,1,1,  S_IDLE, 3,0,1);
        add(0,0,0,1,  S_IDLE, 0,0,0);
        add(0,0,0,8,  S_IDLE, 0,0,0);
        add(0,1,0,2,  S_IDLE, 0,0,0);

        for (int i = 0; i < vt.size(); i++) begin
            start_btn = vt[i].s; stop_btn = vt[i].p; clr_btn = vt[i].c;
            tick();
            start_btn = 1'b0; stop_btn = 1'b0; clr_btn = 1'b0;
            for (int k = 1; k < vt[i].n; k++) tick();
            chk($sformatf("vec%0d_state", i), int'(state), vt[i].st);
            chk($sformatf("vec%0d_count", i), int'(count), vt[i].cnt);
            chk($sformatf("vec%0d_en", i), int'(cnt_en), int'(vt[i].en));
            chk($sformatf("vec%0d_clr", i), int'(cnt_clr), int'(vt[i].clr));
        end
`else
        // Continuous wrap: 0..LIMIT then back to 0, never DONE.
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        saw_clr = 0; saw_done = 0;
        seq.push_back(int'(count));
        repeat (30) begin
            tick();
            if (cnt_clr) saw_clr = 1;
            if (done) saw_done = 1;
            if (int'(count) != seq[$]) seq.push_back(int'(count));
        end
        exp_seq = '{0, 1, 2, 3, 4, 5, 0, 1};
        chk("wrap_seq_len", seq.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < seq.size(); i++)
            chk($sformatf("wrap_seq%0d", i), seq[i], exp_seq[i]);
        chk("wrap_saw_clr", int'(saw_clr), 1);
        chk("wrap_done", int'(saw_done), 0);
`endif

        // Randomized traffic against the model.
        repeat (3000) begin
            rst       = ($urandom_range(0, 299) == 0);
            start_btn = ($urandom_range(0, 9) < 2);
            stop_btn  = ($urandom_range(0, 19) == 0);
            clr_btn   = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
